// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: multi-denomination coin credit, vend with exact change,
// cancel/refund and stock tracking. Define VEND_TIMEOUT_EN to refund credit idle in ACCUM for TIMEOUT cycles.
module vending_ctrl_param #(
    parameter int UNIT_W     = 4,
    parameter int PRICE      = 3,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [1:0]         coin,
    input  logic               cancel,
    input  logic               restock,
    output logic               coin_accept,
    output logic               coin_reject,
    output logic               vend,
    output logic               change_valid,
    output logic [UNIT_W-1:0]  change,
    output logic [UNIT_W-1:0]  credit,
    output logic [STOCK_W-1:0] stock,
    output logic               sold_out,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    // Coin handshake: a coin is taken on an edge with coin_valid=1 and busy=0; exactly one of
    // coin_accept/coin_reject pulses in the following cycle, and the source holds coin until then.
    // state_dbg encoding: 0 IDLE, 1 ACCUM, 2 VEND, 3 REFUND.

    localparam int                 SW           = UNIT_W + 3;
    localparam logic [SW-1:0]      CREDIT_MAX   = SW'((2 ** UNIT_W) - 1);
    localparam logic [SW-1:0]      PRICE_W      = SW'(PRICE);
    localparam logic [UNIT_W-1:0]  PRICE_U      = UNIT_W'(PRICE);
    localparam logic [STOCK_W-1:0] STOCK_RELOAD = STOCK_W'(STOCK_INIT);

    if (PRICE < 1 || PRICE > (2 ** UNIT_W) - 1 || TIMEOUT < 1) begin : g_param_check
        $error("vending_ctrl_param: PRICE or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_VEND   = 2'd2,
        S_REFUND = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] coin_units;
    logic [SW-1:0] credit_sum;
    logic          coin_ok;
    logic          coin_take;
    logic          tmo_hit;

    always_comb begin
        coin_units = '0;
        case (coin)
            2'b01:   coin_units = SW'(1);
            2'b10:   coin_units = SW'(2);
            2'b11:   coin_units = SW'(4);
            default: coin_units = '0;
        endcase
    end

    // Sum is computed wider than credit so an overflowing coin is detected, not wrapped.
    assign credit_sum = SW'(credit) + coin_units;
    assign busy       = (state == S_VEND) || (state == S_REFUND);
    assign sold_out   = (stock == '0);
    assign state_dbg  = state;
    assign coin_ok    = (coin != 2'b00) && !sold_out && (credit_sum <= CREDIT_MAX) && !cancel;
    assign coin_take  = coin_valid && !busy && coin_ok;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == S_ACCUM) && !cancel && !coin_take && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != S_ACCUM || cancel || coin_take || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            credit       <= '0;
            change       <= '0;
            stock        <= STOCK_RELOAD;
            coin_accept  <= 1'b0;
            coin_reject  <= 1'b0;
            vend         <= 1'b0;
            change_valid <= 1'b0;
        end else begin
            coin_accept  <= 1'b0;
            coin_reject  <= 1'b0;
            vend         <= 1'b0;
            change_valid <= 1'b0;
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (restock) begin
                        stock <= STOCK_RELOAD;
                    end
                    if (coin_valid) begin
                        coin_accept <= coin_ok;
                        coin_reject <= !coin_ok;
                    end
                    // A coin colliding with cancel is rejected, so coin_take and cancel never both win.
                    if (coin_take) begin
                        credit <= credit_sum[UNIT_W-1:0];
                        state  <= (credit_sum >= PRICE_W) ? S_VEND : S_ACCUM;
                    end else if (state == S_ACCUM && (cancel || tmo_hit)) begin
                        state <= S_REFUND;
                    end
                end
                S_VEND: begin
                    vend         <= 1'b1;
                    change_valid <= 1'b1;
                    change       <= credit - PRICE_U;
                    credit       <= '0;
                    if (!sold_out) begin
                        stock <= stock - STOCK_W'(1);
                    end
                    state <= S_IDLE;
                end
                default: begin
                    change_valid <= 1'b1;
                    change       <= credit;
                    credit       <= '0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: two instances (default and PRICE=14/STOCK_INIT=1) checked every cycle
// against a credit/stock model, plus directed scenarios with literal expectations.
module tb_vending_ctrl_param;

    localparam int UNIT_W  = 4;
    localparam int STOCK_W = 4;
    localparam int TIMEOUT = 16;
    localparam int PRICE_A = 3;
    localparam int STOCK_A = 8;
    localparam int PRICE_B = 14;
    localparam int STOCK_B = 1;
    localparam int CMAX    = (2 ** UNIT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               coin_valid   [2];
    logic [1:0]         coin         [2];
    logic               cancel       [2];
    logic               restock      [2];
    logic               coin_accept  [2];
    logic               coin_reject  [2];
    logic               vend         [2];
    logic               change_valid [2];
    logic [UNIT_W-1:0]  change       [2];
    logic [UNIT_W-1:0]  credit       [2];
    logic [STOCK_W-1:0] stock        [2];
    logic               sold_out     [2];
    logic               busy         [2];
    logic [1:0]         state_dbg    [2];

    vending_ctrl_param #(.UNIT_W(UNIT_W), .PRICE(PRICE_A), .STOCK_W(STOCK_W),
                         .STOCK_INIT(STOCK_A), .TIMEOUT(TIMEOUT)) u_dut_a (
        .clk(clk), .rst(rst), .coin_valid(coin_valid[0]), .coin(coin[0]), .cancel(cancel[0]),
        .restock(restock[0]), .coin_accept(coin_accept[0]), .coin_reject(coin_reject[0]),
        .vend(vend[0]), .change_valid(change_valid[0]), .change(change[0]), .credit(credit[0]),
        .stock(stock[0]), .sold_out(sold_out[0]), .busy(busy[0]), .state_dbg(state_dbg[0])
    );

    vending_ctrl_param #(.UNIT_W(UNIT_W), .PRICE(PRICE_B), .STOCK_W(STOCK_W),
                         .STOCK_INIT(STOCK_B), .TIMEOUT(TIMEOUT)) u_dut_b (
        .clk(clk), .rst(rst), .coin_valid(coin_valid[1]), .coin(coin[1]), .cancel(cancel[1]),
        .restock(restock[1]), .coin_accept(coin_accept[1]), .coin_reject(coin_reject[1]),
        .vend(vend[1]), .change_valid(change_valid[1]), .change(change[1]), .credit(credit[1]),
        .stock(stock[1]), .sold_out(sold_out[1]), .busy(busy[1]), .state_dbg(state_dbg[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pend: 0 nothing pending, 1 a sale completes next edge, 2 a refund completes next edge.
    int m_credit [2];
    int m_stock  [2];
    int m_change [2];
    int m_pend   [2];
    int m_idle   [2];
    bit e_acc [2];
    bit e_rej [2];
    bit e_vnd [2];
    bit e_cv  [2];

    function automatic int price_of(input int d);
        return (d == 0) ? PRICE_A : PRICE_B;
    endfunction

    function automatic int stock_init_of(input int d);
        return (d == 0) ? STOCK_A : STOCK_B;
    endfunction

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic void model_step(input int d, input logic r, input logic cv, input logic [1:0] cn,
                                       input logic ca, input logic rs);
        int  v;
        bit  accum;
        bit  took;
        e_acc[d] = 1'b0;
        e_rej[d] = 1'b0;
        e_vnd[d] = 1'b0;
        e_cv[d]  = 1'b0;
        if (r) begin
            m_credit[d] = 0;
            m_stock[d]  = stock_init_of(d);
            m_change[d] = 0;
            m_pend[d]   = 0;
            m_idle[d]   = 0;
            return;
        end
        if (m_pend[d] == 1) begin
            e_vnd[d]    = 1'b1;
            e_cv[d]     = 1'b1;
            m_change[d] = m_credit[d] - price_of(d);
            m_credit[d] = 0;
            if (m_stock[d] > 0) m_stock[d] = m_stock[d] - 1;
            m_pend[d]   = 0;
            return;
        end
        if (m_pend[d] == 2) begin
            e_cv[d]     = 1'b1;
            m_change[d] = m_credit[d];
            m_credit[d] = 0;
            m_pend[d]   = 0;
            return;
        end
        accum = (m_credit[d] > 0);
        took  = 1'b0;
        if (cv) begin
            v = coin_units(cn);
            if (v == 0 || m_stock[d] == 0 || m_credit[d] + v > CMAX || ca) begin
                e_rej[d] = 1'b1;
            end else begin
                e_acc[d]    = 1'b1;
                took        = 1'b1;
                m_credit[d] = m_credit[d] + v;
                m_idle[d]   = 0;
                if (m_credit[d] >= price_of(d)) m_pend[d] = 1;
            end
        end
        if (accum && ca) begin
            m_pend[d] = 2;
            m_idle[d] = 0;
        end
`ifdef VEND_TIMEOUT_EN
        else if (accum && !took) begin
            m_idle[d] = m_idle[d] + 1;
            if (m_idle[d] >= TIMEOUT) begin
                m_pend[d] = 2;
                m_idle[d] = 0;
            end
        end
`endif
        if (rs) m_stock[d] = stock_init_of(d);
    endfunction

    function automatic int exp_state(input int d);
        if (m_pend[d] == 1) return 2;
        if (m_pend[d] == 2) return 3;
        return (m_credit[d] > 0) ? 1 : 0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            model_step(d, rst, coin_valid[d], coin[d], cancel[d], restock[d]);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("coin_accept",  d, 32'(coin_accept[d]),  32'(e_acc[d]));
            check("coin_reject",  d, 32'(coin_reject[d]),  32'(e_rej[d]));
            check("vend",         d, 32'(vend[d]),         32'(e_vnd[d]));
            check("change_valid", d, 32'(change_valid[d]), 32'(e_cv[d]));
            check("change",       d, 32'(change[d]),       32'(m_change[d]));
            check("credit",       d, 32'(credit[d]),       32'(m_credit[d]));
            check("stock",        d, 32'(stock[d]),        32'(m_stock[d]));
            check("sold_out",     d, 32'(sold_out[d]),     32'(m_stock[d] == 0));
            check("busy",         d, 32'(busy[d]),         32'(m_pend[d] != 0));
            check("state_dbg",    d, 32'(state_dbg[d]),    32'(exp_state(d)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_coin(input int d, input logic [1:0] code, input bit with_cancel,
                             input bit with_restock, output bit accepted);
        bit done;
        done     = 1'b0;
        accepted = 1'b0;
        @(negedge clk);
        coin_valid[d] = 1'b1;
        coin[d]       = code;
        cancel[d]     = with_cancel;
        restock[d]    = with_restock;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cancel[d]  = 1'b0;
            restock[d] = 1'b0;
            if (coin_accept[d] || coin_reject[d]) begin
                done     = 1'b1;
                accepted = coin_accept[d];
            end
        end
        coin_valid[d] = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout[%0d] got no ack expected ack within 20 cycles", d);
        end
    endtask

    task automatic pulse_cancel(input int d);
        @(negedge clk);
        cancel[d] = 1'b1;
        @(negedge clk);
        cancel[d] = 1'b0;
    endtask

    task automatic pulse_restock(input int d);
        @(negedge clk);
        restock[d] = 1'b1;
        @(negedge clk);
        restock[d] = 1'b0;
    endtask

    task automatic random_phase(input int d, input int iters, input int restock_pct);
        bit acc;
        int r;
        for (int i = 0; i < iters; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                send_coin(d, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 99) < restock_pct), acc);
            end else if (r < 72) begin
                pulse_cancel(d);
            end else if (r < 80) begin
                pulse_restock(d);
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit acc;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            coin_valid[d] = 1'b0;
            coin[d]       = 2'b00;
            cancel[d]     = 1'b0;
            restock[d]    = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("reset_stock_a", 0, 32'(stock[0]), 32'd8);
        check("reset_sold_out_b", 1, 32'(sold_out[1]), 32'd0);
        rst = 1'b0;

        // Exact price: 1+1+1 units.
        for (int k = 1; k <= 3; k++) begin
            send_coin(0, 2'b01, 1'b0, 1'b0, acc);
            check("exact_accept", 0, 32'(acc), 32'd1);
            check("exact_credit", 0, 32'(credit[0]), 32'(k));
        end
        @(negedge clk);
        check("exact_vend", 0, 32'(vend[0]), 32'd1);
        check("exact_cv", 0, 32'(change_valid[0]), 32'd1);
        check("exact_change", 0, 32'(change[0]), 32'd0);
        check("exact_stock", 0, 32'(stock[0]), 32'd7);

        // Overpay: 2+2 units.
        send_coin(0, 2'b10, 1'b0, 1'b0, acc);
        send_coin(0, 2'b10, 1'b0, 1'b0, acc);
        @(negedge clk);
        check("overpay_vend", 0, 32'(vend[0]), 32'd1);
        check("overpay_change", 0, 32'(change[0]), 32'd1);
        check("overpay_credit", 0, 32'(credit[0]), 32'd0);

        // Refund of 2 units.
        send_coin(0, 2'b10, 1'b0, 1'b0, acc);
        pulse_cancel(0);
        @(negedge clk);
        check("refund_cv", 0, 32'(change_valid[0]), 32'd1);
        check("refund_change", 0, 32'(change[0]), 32'd2);
        check("refund_vend", 0, 32'(vend[0]), 32'd0);
        check("refund_state", 0, 32'(state_dbg[0]), 32'd0);

        // Invalid coin, then coin colliding with cancel in ACCUM.
        send_coin(0, 2'b00, 1'b0, 1'b0, acc);
        check("invalid_reject", 0, 32'(coin_reject[0]), 32'd1);
        send_coin(0, 2'b01, 1'b0, 1'b0, acc);
        send_coin(0, 2'b01, 1'b1, 1'b0, acc);
        check("collide_reject", 0, 32'(acc), 32'd0);
        @(negedge clk);
        check("collide_refund", 0, 32'(change[0]), 32'd1);
        check("collide_cv", 0, 32'(change_valid[0]), 32'd1);

        // Idle credit in ACCUM.
        send_coin(0, 2'b01, 1'b0, 1'b0, acc);
`ifdef VEND_TIMEOUT_EN
        repeat (20) @(negedge clk);
        check("timeout_change", 0, 32'(change[0]), 32'd1);
        check("timeout_credit", 0, 32'(credit[0]), 32'd0);
`else
        repeat (100) @(negedge clk);
        check("hold_credit", 0, 32'(credit[0]), 32'd1);
        check("hold_state", 0, 32'(state_dbg[0]), 32'd1);
        pulse_cancel(0);
        @(negedge clk);
`endif

        // Reset mid-operation discards credit without a refund strobe.
        send_coin(0, 2'b10, 1'b0, 1'b0, acc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_credit", 0, 32'(credit[0]), 32'd0);
        check("rst_cv", 0, 32'(change_valid[0]), 32'd0);
        check("rst_stock", 0, 32'(stock[0]), 32'd8);

        // Sell out A with eight 4-unit coins, then reject and restock.
        for (int k = 0; k < 8; k++) send_coin(0, 2'b11, 1'b0, 1'b0, acc);
        @(negedge clk);
        check("soldout_flag", 0, 32'(sold_out[0]), 32'd1);
        send_coin(0, 2'b11, 1'b0, 1'b0, acc);
        check("soldout_reject", 0, 32'(acc), 32'd0);
        pulse_restock(0);
        check("restock_stock", 0, 32'(stock[0]), 32'd8);
        check("restock_sold_out", 0, 32'(sold_out[0]), 32'd0);

        // B: overflow guard at PRICE=14, then single-stock sell-out with restock collision.
        for (int k = 0; k < 3; k++) send_coin(1, 2'b11, 1'b0, 1'b0, acc);
        send_coin(1, 2'b11, 1'b0, 1'b0, acc);
        check("overflow_reject", 1, 32'(acc), 32'd0);
        check("overflow_credit", 1, 32'(credit[1]), 32'd12);
        send_coin(1, 2'b10, 1'b0, 1'b0, acc);
        @(negedge clk);
        check("b_vend", 1, 32'(vend[1]), 32'd1);
        check("b_change", 1, 32'(change[1]), 32'd0);
        check("b_sold_out", 1, 32'(sold_out[1]), 32'd1);
        send_coin(1, 2'b11, 1'b0, 1'b1, acc);
        check("b_restock_reject", 1, 32'(acc), 32'd0);
        check("b_restock_stock", 1, 32'(stock[1]), 32'd1);

        random_phase(0, 300, 5);
        random_phase(1, 300, 25);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish expected finish before 500000");
        $fatal(1);
    end

endmodule
